// File: rtl/arb5_8b_rr_pkg.sv
// Shared constants and state encoding for the five-requester round-robin arbiter.
package arb5_8b_rr_pkg;

    localparam int unsigned ARB_N_REQ = 5;
    localparam int unsigned ARB_SRC_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb5_8b_rr_if.sv
// Requester-side and sink-side handshake bundle of the round-robin arbiter.
interface arb5_8b_rr_if #(
    parameter int unsigned DW = 8
);
    import arb5_8b_rr_pkg::*;

    logic [ARB_N_REQ-1:0]    req_valid;
    logic [ARB_N_REQ*DW-1:0] req_data;
    logic [ARB_N_REQ-1:0]    req_last;
    logic [ARB_N_REQ-1:0]    req_ready;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    logic                    out_last;
    logic [ARB_SRC_W-1:0]    out_src;
    logic                    out_ready;
    logic                    busy;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_src, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_src, busy
    );

endinterface

// File: rtl/mux5_8b.sv
// 5:1 8-bit AND-OR mask mux; select values 5..7 yield zero.
module mux5_8b (
    input  logic [2:0]  i_sel,
    input  logic [39:0] i_data,
    output logic [7:0]  o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < 5; i++) begin
            o_data = o_data | (i_data[i*8 +: 8] & {8{i_sel == 3'(i)}});
        end
    end

endmodule

// File: rtl/arb5_8b_rr.sv
// Burst-locked round-robin arbiter sharing one 8-bit output stream between five requesters.
module arb5_8b_rr
    import arb5_8b_rr_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    arb5_8b_rr_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST);

    arb_state_e           r_state;
    logic [ARB_SRC_W-1:0] r_sel;
    logic [ARB_SRC_W-1:0] r_ptr;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 r_out_valid;
    logic [DW-1:0]        r_out_data;
    logic                 r_out_last;
    logic [ARB_SRC_W-1:0] r_out_src;

    logic [ARB_SRC_W-1:0] w_pick;
    logic [ARB_N_REQ-1:0] w_req_ready;
    logic                 w_ready_sel;
    logic                 w_accept;
    logic                 w_burst_end;
    logic [DW-1:0]        w_mux_data;

    // First valid index after ptr, wrapping modulo the requester count.
    function automatic logic [ARB_SRC_W-1:0] f_rr_next(input logic [ARB_SRC_W-1:0] ptr,
                                                       input logic [ARB_N_REQ-1:0] valid);
        logic [ARB_SRC_W-1:0] idx;
        f_rr_next = ptr;
        for (int k = int'(ARB_N_REQ); k >= 1; k--) begin
            idx = ARB_SRC_W'((int'(ptr) + k) % int'(ARB_N_REQ));
            if (valid[idx]) f_rr_next = idx;
        end
    endfunction

    mux5_8b u_mux (
        .i_sel  (r_sel),
        .i_data (bus.req_data),
        .o_data (w_mux_data)
    );

    always_comb begin
        w_pick      = f_rr_next(r_ptr, bus.req_valid);
        w_ready_sel = !r_out_valid || bus.out_ready;
        w_accept    = (r_state == ST_GRANT) && bus.req_valid[r_sel] && w_ready_sel;
        w_burst_end = bus.req_last[r_sel] || (r_beat_cnt == CNT_W'(MAX_BURST - 1));
        w_req_ready = '0;
        if (r_state == ST_GRANT) w_req_ready[r_sel] = w_ready_sel;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_ptr       <= ARB_SRC_W'(ARB_N_REQ - 1);
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else begin
            // A new beat overwrites the register even when the old one drains this cycle.
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_last  <= w_burst_end;
                r_out_src   <= r_sel;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        r_sel      <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_burst_end) begin
                            r_ptr   <= r_sel;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_src   = r_out_src;
    assign bus.busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_arb5_8b_rr.sv
// Directed bench for arb5_8b_rr: per-cycle compare against a transaction-level model plus literal checks.
module tb_arb5_8b_rr;
    import arb5_8b_rr_pkg::*;

    localparam int MAXB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb5_8b_rr_if #(.DW(8)) bus ();

    arb5_8b_rr #(.DW(8), .MAX_BURST(MAXB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Per-requester beat lists {last, data}
    logic [8:0]  beats [5][64];
    int          head  [5];
    int          tail  [5];
    logic [4:0]  hs;
    logic [4:0]  exp_ready;
    logic [11:0] log_q [$];
    int          base;

    // Model: owner -1 means nobody holds the stream
    int          m_owner = -1;
    int          m_ptr   = 4;
    int          m_cnt   = 0;
    logic        m_ov    = 1'b0;
    logic [7:0]  m_od    = 8'h00;
    logic        m_ol    = 1'b0;
    int          m_os    = 0;
    logic        m_acc;
    logic        m_fin;
    int          m_pick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        beats[r][tail[r]] = {last, d};
        tail[r]++;
    endtask

    function automatic logic pending();
        pending = 1'b0;
        for (int i = 0; i < 5; i++) if (head[i] < tail[i]) pending = 1'b1;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 500 && (pending() || bus.out_valid || bus.busy)) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain bound"}, 32'(n < 500), 32'd1);
    endtask

    task automatic check_log(input string name, input int pos, input logic [2:0] s,
                             input logic l, input logic [7:0] d);
        logic [11:0] act;
        act = (pos < log_q.size()) ? log_q[pos] : 12'hfff;
        check(name, 32'(act), 32'({s, l, d}));
    endtask

    // Requester driver: advance past beats handshaken at the previous sample point
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 5; i++) begin
                if (hs[i] && head[i] < tail[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_last[i]          = beats[i][head[i]][8];
                    bus.req_data[i*8 +: 8]   = beats[i][head[i]][7:0];
                end else begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_last[i]          = 1'b0;
                    bus.req_data[i*8 +: 8]   = 8'h00;
                end
            end
        end
    end

    // Behavioural model: who owns the stream and what beat sits in the output slot
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_ptr = 4; m_cnt = 0;
                m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_os = 0;
            end else begin
                m_acc = (m_owner >= 0) && bus.req_valid[m_owner] && (!m_ov || bus.out_ready);
                if (m_ov && bus.out_ready) m_ov = 1'b0;
                if (m_owner < 0) begin
                    m_pick = -1;
                    for (int k = 1; k <= 5; k++)
                        if (m_pick < 0 && bus.req_valid[(m_ptr + k) % 5]) m_pick = (m_ptr + k) % 5;
                    if (m_pick >= 0) begin
                        m_owner = m_pick;
                        m_cnt   = 0;
                    end
                end else if (m_acc) begin
                    m_cnt++;
                    m_fin = bus.req_last[m_owner] || (m_cnt == MAXB);
                    m_ov  = 1'b1;
                    m_od  = bus.req_data[m_owner*8 +: 8];
                    m_ol  = m_fin;
                    m_os  = m_owner;
                    if (m_fin) begin
                        m_ptr   = m_owner;
                        m_owner = -1;
                    end
                end
            end
        end
    end

    // Compare DUT to model every cycle; log sink handshakes
    initial begin
        hs = '0;
        forever begin
            @(negedge clk);
            hs        = bus.req_valid & bus.req_ready;
            exp_ready = '0;
            if (m_owner >= 0 && (!m_ov || bus.out_ready)) exp_ready[m_owner] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("busy", 32'(bus.busy), 32'(m_owner >= 0));
            if (m_ov) begin
                check("out_data", 32'(bus.out_data), 32'(m_od));
                check("out_src", 32'(bus.out_src), 32'(m_os));
                check("out_last", 32'(bus.out_last), 32'(m_ol));
            end
            if (bus.out_valid && bus.out_ready)
                log_q.push_back({bus.out_src, bus.out_last, bus.out_data});
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst out_src", 32'(bus.out_src), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;

        // Fairness: all five hold single-beat requests
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 5; r++) push(r, 1'b1, 8'(16 * r + k));
        base = log_q.size();
        drain("fair");
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 5; r++)
                check_log("fair order", base + 5 * k + r, 3'(r), 1'b1, 8'(16 * r + k));

        // Burst lock: req 1 keeps the stream while req 3 waits
        @(posedge clk); #1;
        push(1, 1'b0, 8'h11); push(1, 1'b0, 8'h22); push(1, 1'b0, 8'h33); push(1, 1'b1, 8'h44);
        push(3, 1'b1, 8'h77);
        base = log_q.size();
        drain("burst");
        check_log("burst b0", base + 0, 3'd1, 1'b0, 8'h11);
        check_log("burst b1", base + 1, 3'd1, 1'b0, 8'h22);
        check_log("burst b2", base + 2, 3'd1, 1'b0, 8'h33);
        check_log("burst b3", base + 3, 3'd1, 1'b1, 8'h44);
        check_log("burst next", base + 4, 3'd3, 1'b1, 8'h77);

        // Single beat with exact latency
        @(posedge clk); #1;
        push(2, 1'b1, 8'hA5);
        @(negedge clk);
        check("single c0 ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("single c1 ready", 32'(bus.req_ready), 32'b00100);
        check("single c1 busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("single c2 valid", 32'(bus.out_valid), 32'd1);
        check("single c2 data", 32'(bus.out_data), 32'hA5);
        check("single c2 src", 32'(bus.out_src), 32'd2);
        check("single c2 last", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        check("single c3 busy", 32'(bus.busy), 32'd0);
        check("single c3 valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: sink stalls three cycles while beat 0x41 is held
        @(posedge clk); #1;
        push(4, 1'b0, 8'h40); push(4, 1'b0, 8'h41); push(4, 1'b0, 8'h42); push(4, 1'b1, 8'h43);
        base = log_q.size();
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp held data", 32'(bus.out_data), 32'h41);
            check("bp ready low", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain("bp");
        check("bp count", 32'(log_q.size() - base), 32'd4);
        for (int k = 0; k < 4; k++)
            check_log("bp beat", base + k, 3'd4, 1'(k == 3), 8'(8'h40 + k));

        // Forced release after MAXB beats without last
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) push(0, 1'(k == 19), 8'(8'h80 + k));
        push(1, 1'b1, 8'h55);
        base = log_q.size();
        drain("force");
        for (int k = 0; k < 16; k++)
            check_log("force first", base + k, 3'd0, 1'(k == 15), 8'(8'h80 + k));
        check_log("force other", base + 16, 3'd1, 1'b1, 8'h55);
        for (int k = 16; k < 20; k++)
            check_log("force regrant", base + 1 + k, 3'd0, 1'(k == 19), 8'(8'h80 + k));

        // Asynchronous reset during beat 2 of a req 3 burst
        @(posedge clk); #1;
        push(3, 1'b0, 8'hC0); push(3, 1'b0, 8'hC1); push(3, 1'b0, 8'hC2); push(3, 1'b1, 8'hC3);
        repeat (3) @(posedge clk);
        #3;
        check("pre-rst data", 32'(bus.out_data), 32'hC1);
        rst_n = 1'b0;
        #1;
        check("mid-rst valid", 32'(bus.out_valid), 32'd0);
        check("mid-rst data", 32'(bus.out_data), 32'd0);
        check("mid-rst src", 32'(bus.out_src), 32'd0);
        check("mid-rst ready", 32'(bus.req_ready), 32'd0);
        check("mid-rst busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        for (int r = 0; r < 5; r++) push(r, 1'b1, 8'(8'hD0 + r));
        repeat (2) @(posedge clk);
        #1;
        base  = log_q.size();
        rst_n = 1'b1;
        drain("post-rst");
        for (int r = 0; r < 5; r++)
            check_log("post-rst order", base + r, 3'(r), 1'b1, 8'(8'hD0 + r));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb5_8b_rr.md
# arb5_8b_rr

Round-robin arbiter and sequencer that shares the 8-bit 5:1 mask mux between five streaming requesters and drives one registered output stream. Grants are burst-locked: a winner holds the mux select until it sends a `last` beat or hits a burst-length cap. The block sits in front of any single-consumer 8-bit sink that five producers must share.

## Interface
- `DW`, 8, data width per requester (mux is fixed at 8).
- `MAX_BURST`, 16, beats per grant before forced release (2..256).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  5  per-requester beat valid.
- `req_data`  in  5*DW  requester i data at bits [i*DW +: DW].
- `req_last`  in  5  per-requester end-of-burst flag.
- `req_ready`  out  5  per-requester accept; one-hot or zero.
- `out_valid`  out  1  output beat valid (registered).
- `out_data`  out  DW  output beat (registered).
- `out_last`  out  1  end of granted burst (registered).
- `out_src`  out  3  index 0..4 of beat's requester (registered).
- `out_ready`  in  1  sink accept.
- `busy`  out  1  high in GRANT state.

## Operation
- States: IDLE, GRANT. State register, `sel[2:0]`, `ptr[2:0]` (last granted), `beat_cnt`.
- IDLE: if any `req_valid`, pick first valid index searching ptr+1, ptr+2, … mod 5; load `sel`, clear `beat_cnt`, go GRANT. Else stay.
- GRANT: `req_ready[sel] = !out_valid || out_ready`; all other bits 0. In IDLE all `req_ready` = 0.
- Accept = `req_valid[sel] && req_ready[sel]`: output register loads `req_data[sel]` via mux, `out_src <= sel`, `out_valid <= 1`, `beat_cnt++`.
- `out_last <= req_last[sel] || (beat_cnt == MAX_BURST-1)`.
- On accept with that same `out_last` condition true: `ptr <= sel`, go IDLE.
- Output handshake: `out_valid && out_ready` with no new accept clears `out_valid`; accept and drain in same cycle keeps `out_valid` = 1 with new beat.
- Granted requester dropping `req_valid` mid-burst: grant held, no timeout.
- Values 5..7 never appear on `sel`/`out_src`.

## Timing
- Reset (async assert): state IDLE, `ptr` = 4 (requester 0 has first priority), `sel` = 0, `beat_cnt` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_src` = 0, `busy` = 0, `req_ready` = 0. In-flight output beat discarded.
- Request at cycle 0 in IDLE → GRANT and `req_ready` at cycle 1 → `out_valid` at cycle 2.
- Sustained throughput in a burst: 1 beat/cycle with `out_ready` held high.
- One IDLE bubble cycle between consecutive grants.
- `out_ready` low: `out_data/out_last/out_src` stable, `req_ready` low, no beat lost or duplicated.
- Requests arriving while GRANT are considered only at the next IDLE cycle.

## Structure
- Shared package/header: `ARB_N_REQ` = 5, `ARB_SRC_W` = 3, state encodings `ST_IDLE` = 1'b0, `ST_GRANT` = 1'b1.
- Sub-module: the existing 5:1 8-bit mask mux `mux5_8b` instantiated once, `sel` driving its select and the five `req_data` slices driving its inputs.
- Round-robin next-index search is a local combinational function; no further sub-modules.

## Test plan
- Single beat: req 2 valid cycle 0, data 8'hA5, last 1, `out_ready` 1 → cycle 2 `out_valid` 1, `out_data` 8'hA5, `out_src` 2, `out_last` 1; `busy` 0 by cycle 3.
- Fairness: all five continuously valid single-beat (last 1) → `out_src` sequence 0,1,2,3,4,0,1.
- Burst lock: req 1 sends 8'h11,22,33,44 (last on 44) while req 3 valid with 8'h77 → out 11,22,33,44 src 1 contiguous, then 77 src 3.
- Backpressure: `out_ready` low 3 cycles mid-burst → `out_data` held, `req_ready` 0, resumes with no loss/duplication.
- Forced release: req 0 never asserts last, MAX_BURST 16 → 16th beat has `out_last` 1, next grant goes to next valid requester (e.g. 1), req 0 regranted later.
- Reset mid-burst: `rst_n` low during beat 2 of req 3 → all outputs 0 immediately; after release with all valid, first grant = req 0.
